sprite_rotator: RTL and testbench
=================================

# sprite_rotator

Parametrised N-channel sprite colour/draw-request permuter for the game display path. It sits between the per-character object blocks and the drawing priority mux, and periodically reassigns which character's appearance is shown in which output slot. The reassignment is driven by a timer tick: rotate up, rotate down, hold, or pairwise swap. Outputs are registered, and a synchronous clear realigns the outputs to a straight pass-through.

## Interface
Parameters:
- N_CH, 4: number of channels; legal range 2..16.
- RGB_W, 8: colour width per channel.
- OFF_W, $clog2(N_CH): width of the rotation offset; derived, not overridden.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle permutation-update strobe from the game timer.
- clear  in  1  synchronous realign to identity mapping.
- mode  in  2  requested action, sampled only when tick=1: 00 ROT_UP, 01 ROT_DOWN, 10 HOLD, 11 PAIR.
- dr_in  in  N_CH  per-channel draw request.
- rgb_in  in  N_CH×RGB_W  per-channel colour, packed; channel i is at bits [i*RGB_W +: RGB_W].
- pause  in  1  present only with SPRITE_ROT_PAUSE_EN; freezes all tick actions.
- dr_out  out  N_CH  permuted draw request.
- rgb_out  out  N_CH×RGB_W  permuted colour, same packing as rgb_in.
- offset  out  OFF_W  current rotation offset.
- pair_active  out  1  high while the pair swap is applied.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- State registers:
  - offset: 0..N_CH-1.
  - pair_flag.
  - cur_mode: the last mode sampled on a tick.
- Source select for output channel i:
  - If cur_mode = PAIR and pair_flag = 1: src = i^1. If i^1 ≥ N_CH (odd N_CH, last channel), src = i.
  - Otherwise: src = (i + offset) mod N_CH.
- Each cycle: dr_out[i] <= dr_in[src]; rgb_out[i] <= rgb_in[src].
- Tick actions (tick=1 and clear=0); in every case cur_mode <= mode:
  - ROT_UP: offset <= offset+1, wrapping N_CH-1 → 0. pair_flag <= 0.
  - ROT_DOWN: offset <= offset-1, wrapping 0 → N_CH-1. pair_flag <= 0.
  - HOLD: offset and pair_flag unchanged.
  - PAIR: pair_flag <= ~pair_flag. offset unchanged.
- Leaving PAIR restores rotation at the retained offset.
- Offset arithmetic is done at OFF_W+1 bits and compared against N_CH. Non-power-of-two N_CH must never produce offset ≥ N_CH.
- clear=1:
  - offset <= 0, pair_flag <= 0, cur_mode <= ROT_UP.
  - Outputs load the identity mapping of the current inputs in that same cycle.
  - clear has priority over tick; a simultaneous tick is discarded.
- pair_active = (cur_mode == PAIR) && pair_flag.

## Timing
- Reset values:
  - dr_out = 0, rgb_out = 0, offset = 0, pair_active = 0.
  - cur_mode = ROT_UP, pair_flag = 0.
- Data latency is 1 cycle: inputs at edge k appear on the outputs after edge k.
- A tick at edge k updates the state at edge k. Data captured at edge k still uses the old mapping; the new mapping applies from the capture at edge k+1.
- Consecutive ticks on back-to-back cycles each act; there is no minimum spacing.
- A mode change without a tick has no effect.
- Reset asserted mid-operation returns everything to reset values immediately. It is asynchronous; deassertion is expected synchronised upstream.

## Configuration
- SPRITE_ROT_PAUSE_EN defined:
  - The pause port exists.
  - While pause=1, ticks are ignored: offset, pair_flag and cur_mode hold.
  - Data still flows with 1-cycle latency.
  - clear still acts while paused.
- SPRITE_ROT_PAUSE_EN undefined: no pause port, and every tick acts.

## Structure
- Package sprite_rot_pkg:
  - Mode enum (ROT_UP, ROT_DOWN, HOLD, PAIR) with its 2-bit encoding.
  - N_CH legality limit constants.
- Sub-module sprite_rot_src_sel:
  - Combinational function of offset, pair_flag, cur_mode and channel index.
  - Returns src; instantiated once per channel inside a generate loop.
- Top holds the control registers and the output registers.

## Test plan
All scenarios use N_CH=4 and RGB_W=8 unless stated.
- Reset: after reset, all outputs are 0. With dr_in=4'b1111 and rgb_in={8'h44,8'h33,8'h22,8'h11} (ch3..ch0), one cycle later rgb_out ch0..ch3 = 11,22,33,44 and offset=0.
- ROT_UP: four ticks with mode=00 step offset 1,2,3,0. After the first tick, rgb_out ch0 = 22 and ch3 = 11. After the fourth, identity is restored.
- ROT_DOWN wrap: from offset=0, one tick with mode=01 gives offset=3, and rgb_out ch0 = 44.
- PAIR then HOLD: tick with mode=11 gives ch0..ch3 = 22,11,44,33 and pair_active=1. A second PAIR tick restores identity. A HOLD tick keeps the current mapping.
- Priority: clear and tick in the same cycle at offset=2 give offset=0, identity output on the next cycle, and the tick is discarded.
- With N_CH=3: ROT_UP wraps as 2 → 0. In PAIR mode, ch2 passes through unchanged. With SPRITE_ROT_PAUSE_EN and pause=1, ticks leave offset unchanged.

Source files
------------

// File: rtl/sprite_rot_pkg.sv
// sprite_rot_pkg: mode encoding and channel-count limits for sprite_rotator.
package sprite_rot_pkg;

    typedef enum logic [1:0] {
        ROT_UP   = 2'b00,
        ROT_DOWN = 2'b01,
        HOLD     = 2'b10,
        PAIR     = 2'b11
    } rot_mode_e;

    localparam int N_CH_MIN = 2;
    localparam int N_CH_MAX = 16;

endpackage

// File: rtl/sprite_rotator_if.sv
// sprite_rotator_if: control strobes and per-channel data bus of the rotator.
// The pause signal exists only when SPRITE_ROT_PAUSE_EN is defined.
interface sprite_rotator_if #(
    parameter int N_CH  = 4,
    parameter int RGB_W = 8
);
    localparam int OFF_W = $clog2(N_CH);

    logic                   tick;
    logic                   clear;
    logic [1:0]             mode;
    logic [N_CH-1:0]        dr_in;
    logic [N_CH*RGB_W-1:0]  rgb_in;
`ifdef SPRITE_ROT_PAUSE_EN
    logic                   pause;
`endif
    logic [N_CH-1:0]        dr_out;
    logic [N_CH*RGB_W-1:0]  rgb_out;
    logic [OFF_W-1:0]       offset;
    logic                   pair_active;

`ifdef SPRITE_ROT_PAUSE_EN
    modport master (output tick, clear, mode, dr_in, rgb_in, pause,
                    input  dr_out, rgb_out, offset, pair_active);
    modport slave  (input  tick, clear, mode, dr_in, rgb_in, pause,
                    output dr_out, rgb_out, offset, pair_active);
`else
    modport master (output tick, clear, mode, dr_in, rgb_in,
                    input  dr_out, rgb_out, offset, pair_active);
    modport slave  (input  tick, clear, mode, dr_in, rgb_in,
                    output dr_out, rgb_out, offset, pair_active);
`endif

endinterface

// File: rtl/sprite_rot_src_sel.sv
// sprite_rot_src_sel: source channel for one output slot, given the
// current rotation offset and pair-swap state.
module sprite_rot_src_sel
    import sprite_rot_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CH    = 0,
    parameter int OFF_W = $clog2(N_CH)
) (
    input  logic [OFF_W-1:0] offset_i,
    input  logic             pair_flag_i,
    input  rot_mode_e        mode_i,
    output logic [OFF_W-1:0] src_o
);
    // Partner for the pair swap; the unpaired last channel of an odd N_CH maps to itself.
    localparam int PAIR_CH = ((CH ^ 1) < N_CH) ? (CH ^ 1) : CH;

    logic [OFF_W:0] sum;

    // (CH + offset) mod N_CH, one extra bit so the sum cannot overflow before the wrap.
    always_comb begin
        sum = {1'b0, offset_i} + (OFF_W+1)'(CH);
        if (sum >= (OFF_W+1)'(N_CH))
            sum = sum - (OFF_W+1)'(N_CH);
        if (mode_i == PAIR && pair_flag_i)
            src_o = OFF_W'(PAIR_CH);
        else
            src_o = sum[OFF_W-1:0];
    end

endmodule

// File: rtl/sprite_rotator.sv
// sprite_rotator: registered N-channel colour/draw-request permuter.
// Timer ticks rotate, hold or pair-swap the channel mapping; clear realigns to identity.
// Optional: SPRITE_ROT_PAUSE_EN adds a pause input that freezes tick actions.
module sprite_rotator
    import sprite_rot_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int RGB_W = 8,
    localparam int OFF_W = $clog2(N_CH)
) (
    input  logic clk,
    input  logic resetN,
    sprite_rotator_if.slave bus
);
    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("sprite_rotator: N_CH out of range");
    end

    logic [OFF_W-1:0]                 offset_q, offset_d;
    logic                             pair_q, pair_d;
    rot_mode_e                        mode_q, mode_d;
    logic [N_CH-1:0]                  dr_q, dr_d;
    logic [N_CH*RGB_W-1:0]            rgb_q, rgb_d;
    logic [N_CH-1:0][OFF_W-1:0]       src;
    logic                             tick_act;
    logic [OFF_W:0]                   off_up, off_dn;

`ifdef SPRITE_ROT_PAUSE_EN
    assign tick_act = bus.tick && !bus.pause;
`else
    assign tick_act = bus.tick;
`endif

    // Next control state: clear beats tick; offset wraps are detected at OFF_W+1 bits.
    always_comb begin
        offset_d = offset_q;
        pair_d   = pair_q;
        mode_d   = mode_q;
        off_up   = {1'b0, offset_q} + (OFF_W+1)'(1);
        off_dn   = {1'b0, offset_q} - (OFF_W+1)'(1);
        if (bus.clear) begin
            offset_d = '0;
            pair_d   = 1'b0;
            mode_d   = ROT_UP;
        end else if (tick_act) begin
            mode_d = rot_mode_e'(bus.mode);
            case (rot_mode_e'(bus.mode))
                ROT_UP: begin
                    offset_d = (off_up >= (OFF_W+1)'(N_CH)) ? '0 : off_up[OFF_W-1:0];
                    pair_d   = 1'b0;
                end
                ROT_DOWN: begin
                    // Underflow from 0 shows up as a value >= N_CH.
                    offset_d = (off_dn >= (OFF_W+1)'(N_CH)) ? OFF_W'(N_CH-1) : off_dn[OFF_W-1:0];
                    pair_d   = 1'b0;
                end
                PAIR:    pair_d = ~pair_q;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sprite_rot_src_sel #(.N_CH(N_CH), .CH(i), .OFF_W(OFF_W)) u_sel (
            .offset_i    (offset_q),
            .pair_flag_i (pair_q),
            .mode_i      (mode_q),
            .src_o       (src[i])
        );

        // Data mux: identity on clear, otherwise the mapping in force before this edge.
        always_comb begin
            if (bus.clear) begin
                dr_d[i]                     = bus.dr_in[i];
                rgb_d[i*RGB_W +: RGB_W]     = bus.rgb_in[i*RGB_W +: RGB_W];
            end else begin
                dr_d[i]                     = bus.dr_in[src[i]];
                rgb_d[i*RGB_W +: RGB_W]     = bus.rgb_in[src[i]*RGB_W +: RGB_W];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offset_q <= '0;
            pair_q   <= 1'b0;
            mode_q   <= ROT_UP;
            dr_q     <= '0;
            rgb_q    <= '0;
        end else begin
            offset_q <= offset_d;
            pair_q   <= pair_d;
            mode_q   <= mode_d;
            dr_q     <= dr_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.dr_out      = dr_q;
    assign bus.rgb_out     = rgb_q;
    assign bus.offset      = offset_q;
    assign bus.pair_active = (mode_q == PAIR) && pair_q;

endmodule

// File: tb/tb_sprite_rotator.sv
// tb_sprite_rotator: directed checks of sprite_rotator at N_CH=4 and N_CH=3.
module tb_sprite_rotator;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sprite_rotator_if #(.N_CH(4), .RGB_W(8)) b  ();
    sprite_rotator_if #(.N_CH(3), .RGB_W(8)) b3 ();

    sprite_rotator #(.N_CH(4), .RGB_W(8)) dut4 (.clk(clk), .resetN(resetN), .bus(b));
    sprite_rotator #(.N_CH(3), .RGB_W(8)) dut3 (.clk(clk), .resetN(resetN), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.tick = 0; b.clear = 0; b.mode = 2'b00; b.dr_in = '0; b.rgb_in = '0;
        b3.tick = 0; b3.clear = 0; b3.mode = 2'b00; b3.dr_in = 3'b111; b3.rgb_in = 24'h332211;
`ifdef SPRITE_ROT_PAUSE_EN
        b.pause = 0; b3.pause = 0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dr",   32'(b.dr_out), 32'h0);
        chk("rst_rgb",  b.rgb_out, 32'h0);
        chk("rst_off",  32'(b.offset), 32'h0);
        chk("rst_pair", 32'(b.pair_active), 32'h0);
        @(negedge clk);
        resetN = 1;

        // Identity after reset
        b.dr_in = 4'hf; b.rgb_in = 32'h44332211;
        step();
        chk("id_rgb", b.rgb_out, 32'h44332211);
        chk("id_dr",  32'(b.dr_out), 32'hf);
        chk("id_off", 32'(b.offset), 32'h0);
        chk("id3_rgb", 32'(b3.rgb_out), 32'h332211);

        // ROT_UP: state moves at the tick edge, data follows one capture later
        b.tick = 1; b.mode = 2'b00;
        step();
        chk("up1_off", 32'(b.offset), 32'h1);
        b.tick = 0; b.dr_in = 4'b0001;
        step();
        chk("up1_rgb", b.rgb_out, 32'h11443322);
        chk("up1_dr",  32'(b.dr_out), 32'h8);
        b.dr_in = 4'hf; b.tick = 1;
        step(); chk("up2_off", 32'(b.offset), 32'h2);
        step(); chk("up3_off", 32'(b.offset), 32'h3);
        step(); chk("up4_off", 32'(b.offset), 32'h0);
        b.tick = 0;
        step(); chk("up4_rgb", b.rgb_out, 32'h44332211);

        // ROT_DOWN wrap 0 -> 3
        b.tick = 1; b.mode = 2'b01;
        step(); chk("dn_off", 32'(b.offset), 32'h3);
        b.tick = 0;
        step(); chk("dn_rgb", b.rgb_out, 32'h33221144);

        // Clear realigns with identity in the same cycle
        b.clear = 1;
        step();
        chk("clr_off", 32'(b.offset), 32'h0);
        chk("clr_rgb", b.rgb_out, 32'h44332211);
        b.clear = 0;

        // PAIR on, then off
        b.tick = 1; b.mode = 2'b11;
        step(); chk("pr_act", 32'(b.pair_active), 32'h1);
        b.tick = 0;
        step(); chk("pr_rgb", b.rgb_out, 32'h33441122);
        b.tick = 1;
        step(); chk("pr_off_act", 32'(b.pair_active), 32'h0);
        b.tick = 0;
        step(); chk("pr_off_rgb", b.rgb_out, 32'h44332211);

        // Pair at offset 1, then HOLD leaves pair and restores rotation at offset 1
        b.tick = 1; b.mode = 2'b00;
        step(); chk("h_up_off", 32'(b.offset), 32'h1);
        b.mode = 2'b11;
        step();
        chk("h_pr_act", 32'(b.pair_active), 32'h1);
        chk("h_pr_off", 32'(b.offset), 32'h1);
        b.tick = 0;
        step(); chk("h_pr_rgb", b.rgb_out, 32'h33441122);
        b.tick = 1; b.mode = 2'b10;
        step();
        chk("hold_act", 32'(b.pair_active), 32'h0);
        chk("hold_off", 32'(b.offset), 32'h1);
        b.tick = 0;
        step(); chk("hold_rgb", b.rgb_out, 32'h11443322);

        // Mode change without tick does nothing
        b.mode = 2'b01;
        step();
        chk("nt_off", 32'(b.offset), 32'h1);
        chk("nt_rgb", b.rgb_out, 32'h11443322);

        // clear beats a simultaneous tick at offset 2
        b.tick = 1; b.mode = 2'b00;
        step(); chk("pri_pre_off", 32'(b.offset), 32'h2);
        b.clear = 1; b.rgb_in = 32'hddccbbaa;
        step();
        chk("pri_off", 32'(b.offset), 32'h0);
        chk("pri_rgb", b.rgb_out, 32'hddccbbaa);
        b.clear = 0; b.tick = 0;
        step();
        chk("pri_off2", 32'(b.offset), 32'h0);
        chk("pri_rgb2", b.rgb_out, 32'hddccbbaa);

        // Asynchronous reset mid-operation
        b.tick = 1; b.mode = 2'b00;
        step(); chk("ar_pre_off", 32'(b.offset), 32'h1);
        b.tick = 0;
        #2 resetN = 0;
        #1;
        chk("ar_off", 32'(b.offset), 32'h0);
        chk("ar_rgb", b.rgb_out, 32'h0);
        chk("ar_dr",  32'(b.dr_out), 32'h0);
        @(negedge clk);
        resetN = 1;

        // N_CH = 3: wrap 2 -> 0, pair leaves ch2 alone
        b3.tick = 1; b3.mode = 2'b00;
        step(); chk("n3_off1", 32'(b3.offset), 32'h1);
        step(); chk("n3_off2", 32'(b3.offset), 32'h2);
        b3.tick = 0;
        step(); chk("n3_rgb2", 32'(b3.rgb_out), 32'h221133);
        b3.tick = 1;
        step(); chk("n3_wrap", 32'(b3.offset), 32'h0);
        b3.tick = 0;
        step(); chk("n3_rgb0", 32'(b3.rgb_out), 32'h332211);
        b3.tick = 1; b3.mode = 2'b11;
        step(); chk("n3_pr_act", 32'(b3.pair_active), 32'h1);
        b3.tick = 0;
        step(); chk("n3_pr_rgb", 32'(b3.rgb_out), 32'h331122);

`ifdef SPRITE_ROT_PAUSE_EN
        // Paused ticks are ignored; data still flows
        b.rgb_in = 32'h44332211;
        b.pause = 1; b.tick = 1; b.mode = 2'b00;
        step(); chk("ps_off", 32'(b.offset), 32'h0);
        step(); chk("ps_rgb", b.rgb_out, 32'h44332211);
        b.pause = 0; b.tick = 0;
        b3.pause = 1; b3.tick = 1; b3.mode = 2'b00;
        step(); chk("ps3_off", 32'(b3.offset), 32'h0);
        b3.pause = 0; b3.tick = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
